// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues nextpc to the synchronous inst SRAM,
// and presents {inst, pc} to decode, buffering the fetched word across back-pressure.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] fs_inst;

    logic [31:0] inst_buf;
    logic        inst_buf_valid;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Pre-IF: request the next PC every cycle FS can take it.
    assign to_fs_valid = ~reset;
    assign seq_pc      = fs_pc + 32'd4;
    assign nextpc      = br_taken ? br_target : seq_pc;

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = '0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = '0;

    // A redirect squashes the current slot and always lets the target in.
    assign fs_ready_go    = 1'b1;
    assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_allowin) begin
            fs_valid <= to_fs_valid;
            if (to_fs_valid) begin
                fs_pc <= nextpc;
            end
        end
    end

    // SRAM data is only valid the cycle after the request, so hold it while ID stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf       <= '0;
            inst_buf_valid <= 1'b0;
        end else if ((fs_valid & ds_allowin) | br_taken) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid & ~inst_buf_valid & ~ds_allowin) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

    assign fs_inst      = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_bus = {fs_inst, fs_pc};

endmodule
